// File: rtl/pwm_pkg.sv
// Shared types and constants for the register-driven PWM block.
// fade_step() is used only when PWM_FADE_EN is defined.
package pwm_pkg;

    localparam logic [7:0] STEP_MAX     = 8'd254;
    localparam int         CTRL_EN_BIT  = 0;
    localparam int         CTRL_INV_BIT = 1;

    typedef logic [7:0] duty_t;

    // One count toward target; holds once equal, so 0->255 takes 255 calls.
    function automatic duty_t fade_step(input duty_t current, input duty_t target);
        duty_t result;
        result = current;
        if (current < target) begin
            result = current + 8'd1;
        end else if (current > target) begin
            result = current - 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: duty shadow register, step compare and registered output.
// With PWM_FADE_EN defined the shadow ramps one count per period toward duty_in.
module pwm_channel
    import pwm_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  enable,
    input  logic  wrap,
    input  duty_t duty_in,
    input  duty_t step_cnt,
    input  logic  sh_invert,
    output logic  pwm_out
);

    duty_t sh_duty;

    // NOTE: shadows are real state the compare reads on the first enabled
    // clock, so they sit in the reset branch alongside the output flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_duty <= '0;
            pwm_out <= 1'b0;
        end else begin
            if (!enable) begin
                sh_duty <= duty_in;
`ifdef PWM_FADE_EN
            end else if (wrap) begin
                sh_duty <= fade_step(sh_duty, duty_in);
`else
            end else if (wrap) begin
                sh_duty <= duty_in;
`endif
            end
            // Disabled forces 0 whatever the invert shadow says.
            pwm_out <= enable & ((step_cnt < sh_duty) ^ sh_invert);
        end
    end

endmodule

// File: rtl/reg_pwm_driver.sv
// PWM driver fed from the I2C register bank; shadows update only at period wrap.
// Optional build macro PWM_FADE_EN ramps duty one count per period (see pwm_channel).
module reg_pwm_driver
    import pwm_pkg::*;
#(
    parameter int unsigned CHANNELS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [8*CHANNELS-1:0] duty_in,
    input  logic [7:0]            prescale_in,
    input  logic [7:0]            ctrl_in,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic                  period_start,
    output logic                  active
);

    logic  enable;
    logic  tick;
    logic  wrap;
    duty_t pre_cnt;
    duty_t step_cnt;
    duty_t sh_prescale;
    logic  sh_invert;
    logic  unused_ctrl;

    // Enable is deliberately not shadowed: a change acts on the next clock.
    assign enable      = ctrl_in[CTRL_EN_BIT];
    assign unused_ctrl = ^ctrl_in[7:2];

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        tick = 1'b0;
        wrap = 1'b0;
        if (enable) begin
            tick = (pre_cnt == sh_prescale);
            wrap = tick && (step_cnt == STEP_MAX);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_cnt      <= '0;
            step_cnt     <= '0;
            sh_prescale  <= '0;
            sh_invert    <= 1'b0;
            period_start <= 1'b0;
            active       <= 1'b0;
        end else if (!enable) begin
            pre_cnt      <= '0;
            step_cnt     <= '0;
            sh_prescale  <= prescale_in;
            sh_invert    <= ctrl_in[CTRL_INV_BIT];
            period_start <= 1'b0;
            active       <= 1'b0;
        end else begin
            active       <= 1'b1;
            // First clock of step 0 covers both the enable rise and every wrap.
            period_start <= (pre_cnt == 8'd0) && (step_cnt == 8'd0);
            if (tick) begin
                pre_cnt  <= '0;
                step_cnt <= wrap ? 8'd0 : step_cnt + 8'd1;
            end else begin
                pre_cnt  <= pre_cnt + 8'd1;
            end
            if (wrap) begin
                sh_prescale <= prescale_in;
                sh_invert   <= ctrl_in[CTRL_INV_BIT];
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        pwm_channel u_channel (
            .clock     (clock),
            .reset     (reset),
            .enable    (enable),
            .wrap      (wrap),
            .duty_in   (duty_in[8*k +: 8]),
            .step_cnt  (step_cnt),
            .sh_invert (sh_invert),
            .pwm_out   (pwm_out[k])
        );
    end

endmodule

// File: tb/tb_reg_pwm_driver.sv
// Directed bench for reg_pwm_driver: table of single-setting periods plus
// hand sequences for reset, invert change, mid-period write, enable drop and fade.
module tb_reg_pwm_driver;

    localparam int CH = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [8*CH-1:0]   duty_in;
    logic [7:0]        prescale_in;
    logic [7:0]        ctrl_in;
    logic [CH-1:0]     pwm_out;
    logic              period_start;
    logic              active;

    int n_checks = 0;
    int n_fail   = 0;

    reg_pwm_driver #(.CHANNELS(CH)) dut (
        .clock        (clock),
        .reset        (reset),
        .duty_in      (duty_in),
        .prescale_in  (prescale_in),
        .ctrl_in      (ctrl_in),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .active       (active)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] duty;
        logic [7:0] prescale;
        logic       invert;
        int         clocks;
        int         exp_high;
        int         exp_first_low;
        int         exp_ps;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_inputs(input logic [7:0] duty, input logic [7:0] ps,
                              input logic inv, input logic en);
        duty_in     = {CH{duty}};
        prescale_in = ps;
        ctrl_in     = {6'b0, inv, en};
    endtask

    // Disable long enough to load shadows, then enable; returns positioned on
    // the first sample of step 0 (index 0 of the period).
    task automatic start(input logic [7:0] duty, input logic [7:0] ps, input logic inv);
        set_inputs(duty, ps, inv, 1'b0);
        step();
        step();
        ctrl_in[0] = 1'b1;
        step();
    endtask

    task automatic window(input int n, output int high, output int first_low,
                          output int ps_cnt, output int first_ps, output int split);
        high = 0; first_low = n; ps_cnt = 0; first_ps = -1; split = 0;
        for (int i = 0; i < n; i++) begin
            if (pwm_out[0]) high++;
            else if (first_low == n) first_low = i;
            if (period_start) begin
                ps_cnt++;
                if (first_ps < 0) first_ps = i;
            end
            if (pwm_out != {CH{pwm_out[0]}}) split++;
            step();
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, fl, pc, fp, sp;

        vecs[0] = '{8'h00, 8'd0, 1'b0,  765,   0,   0, 3};
        vecs[1] = '{8'h40, 8'd0, 1'b0,  255,  64,  64, 1};
        vecs[2] = '{8'hFF, 8'd0, 1'b1,  255,   0,   0, 1};
        vecs[3] = '{8'h02, 8'd3, 1'b0, 1020,   8,   8, 1};
        vecs[4] = '{8'h80, 8'd0, 1'b0,  255, 128, 128, 1};
        vecs[5] = '{8'hFF, 8'd0, 1'b0,  510, 510, 510, 2};
        vecs[6] = '{8'h01, 8'd0, 1'b1,  255, 254,   0, 1};

        // Reset state
        reset = 1'b1;
        set_inputs(8'h00, 8'd0, 1'b0, 1'b0);
        step();
        step();
        check("reset pwm_out", int'(pwm_out), 0);
        check("reset active", int'(active), 0);
        check("reset period_start", int'(period_start), 0);
        reset = 1'b0;
        step();

        // Reset asserted mid-run while the output is high
        start(8'h80, 8'd0, 1'b0);
        window(20, hi, fl, pc, fp, sp);
        check("pre-reset high count", hi, 20);
        #2;
        reset = 1'b1;
        #1;
        check("async reset pwm_out", int'(pwm_out), 0);
        check("async reset active", int'(active), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Table-driven single-setting periods
        for (int v = 0; v < 7; v++) begin
            start(vecs[v].duty, vecs[v].prescale, vecs[v].invert);
            check($sformatf("v%0d active", v), int'(active), 1);
            window(vecs[v].clocks, hi, fl, pc, fp, sp);
            check($sformatf("v%0d high clocks", v), hi, vecs[v].exp_high);
            check($sformatf("v%0d first low", v), fl, vecs[v].exp_first_low);
            check($sformatf("v%0d period_start count", v), pc, vecs[v].exp_ps);
            check($sformatf("v%0d first period_start", v), fp, 0);
            check($sformatf("v%0d channel split", v), sp, 0);
        end

        // Invert change takes effect only after the next wrap
        start(8'hFF, 8'd0, 1'b1);
        window(255, hi, fl, pc, fp, sp);
        check("inv1 high", hi, 0);
        ctrl_in[1] = 1'b0;
        window(255, hi, fl, pc, fp, sp);
        check("inv change same period", hi, 0);
        window(255, hi, fl, pc, fp, sp);
        check("inv0 after wrap", hi, 255);

        // Mid-period duty write at step 10
        start(8'h80, 8'd0, 1'b0);
        window(10, hi, fl, pc, fp, sp);
        check("mid write head high", hi, 10);
        duty_in = {CH{8'h10}};
        window(245, hi, fl, pc, fp, sp);
        check("mid write tail high", hi, 118);
        window(255, hi, fl, pc, fp, sp);
        check("mid write next high", hi, 16);
        check("mid write next first low", fl, 16);

        // Enable dropped at step 100, then re-enabled
        start(8'h80, 8'd0, 1'b0);
        window(100, hi, fl, pc, fp, sp);
        check("drop pre pwm", int'(pwm_out[0]), 1);
        ctrl_in[0] = 1'b0;
        step();
        check("drop pwm_out", int'(pwm_out), 0);
        check("drop active", int'(active), 0);
        check("drop period_start", int'(period_start), 0);
        ctrl_in[0] = 1'b1;
        step();
        check("reenable period_start", int'(period_start), 1);
        check("reenable active", int'(active), 1);
        check("reenable pwm", int'(pwm_out[0]), 1);
        window(255, hi, fl, pc, fp, sp);
        check("reenable high", hi, 128);

        // Duty request 0x00 -> 0x03 issued mid-period
        start(8'h00, 8'd0, 1'b0);
        window(5, hi, fl, pc, fp, sp);
        duty_in = {CH{8'h03}};
        window(250, hi, fl, pc, fp, sp);
        check("fade period0 high", hi, 0);
        for (int p = 1; p <= 3; p++) begin
`ifdef PWM_FADE_EN
            window(255, hi, fl, pc, fp, sp);
            check($sformatf("fade period%0d high", p), hi, p);
`else
            window(255, hi, fl, pc, fp, sp);
            check($sformatf("fade period%0d high", p), hi, 3);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_pwm_driver.md
Name: reg_pwm_driver

Overview:
- Consumes the packed register bank written over the I2C slave: one duty byte per channel, plus a shared prescale byte and a control byte.
- Produces glitch-free PWM outputs on the chip pins.
- Register values are staged in shadow registers and take effect only at a PWM period boundary, so an I2C write landing mid-period never produces a runt pulse.
- Sits directly downstream of the I2C register memory, in the same single clock domain.

Parameters:
- CHANNELS, 4, number of PWM outputs (1..8).

Ports:
- clock  input  1  system clock; sole clock of the block.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- duty_in  input  8*CHANNELS  packed duty bytes; channel k uses bits [8k+7:8k].
- prescale_in  input  8  tick divider; one PWM step occurs every prescale_in+1 clocks.
- ctrl_in  input  8  bit0 = global enable; bit1 = invert outputs; bits[7:2] ignored.
- pwm_out  output  CHANNELS  PWM outputs (registered).
- period_start  output  1  one-cycle pulse on the first step of each period.
- active  output  1  registered copy of the running enable.

Behaviour:
- Reset:
  - pwm_out = 0, period_start = 0, active = 0.
  - pre_cnt and step_cnt = 0.
  - All shadow registers = 0.
- Disabled (ctrl_in[0] = 0):
  - pre_cnt and step_cnt held at 0.
  - Shadows reload from the inputs every cycle.
  - pwm_out = 0 regardless of invert; active = 0.
- Enable rise (ctrl_in[0] 0->1, cycle N):
  - Shadows are already current; counting starts from pre_cnt = 0, step_cnt = 0.
  - active = 1 and period_start = 1 at cycle N+1.
- Prescaler:
  - 8-bit pre_cnt increments each clock.
  - When pre_cnt == sh_prescale: tick = 1 and pre_cnt returns to 0.
  - sh_prescale = 0 gives a tick every clock.
- Step counter:
  - 8-bit step_cnt advances on each tick over the range 0..254.
  - On a tick at 254 it wraps to 0, so a period is 255 steps = 255*(sh_prescale+1) clocks.
- Wrap event: on the tick that wraps step_cnt to 0:
  - sh_duty[k], sh_prescale and sh_invert load from the inputs in the same cycle.
  - period_start pulses in the next cycle.
- Channel output:
  - raw_k = (step_cnt < sh_duty[k]).
  - pwm_out[k] is registered as raw_k XOR sh_invert, i.e. 1 clock of latency from step_cnt.
  - Duty 0 gives a constant 0; duty 255 gives a constant 1, since step_cnt never reaches 255.
  - Duty d gives high for d steps of every 255.
- Input changes mid-period:
  - Changes to duty_in, prescale_in or ctrl_in[1] take no effect until the next wrap.
  - Exception: a change of ctrl_in[0] takes effect on the next clock.
- Enable fall mid-period: outputs go to 0 on the next clock and counters clear; there is no period completion.
- Reset mid-period: outputs go to 0 immediately (asynchronously).
- Arithmetic: all counters are unsigned 8-bit; comparisons are unsigned; no counter ever reaches an overflow condition.

Optional Feature:
- Macro: PWM_FADE_EN.
- Defined:
  - At each wrap, sh_duty[k] moves one count toward duty_in[k] (+1 or -1, or holds if equal) instead of jumping.
  - A full 0->255 fade therefore takes 255 periods.
  - While disabled, sh_duty[k] still loads directly.
- Not defined: sh_duty[k] loads duty_in[k] directly at each wrap, as described above.

Decomposition:
- Shared package pwm_pkg:
  - localparam STEP_MAX = 8'd254.
  - CTRL_EN_BIT = 0, CTRL_INV_BIT = 1.
  - typedef logic [7:0] duty_t.
- Sub-module pwm_channel, instantiated CHANNELS times, owns per channel:
  - the duty shadow register (plus fade logic when PWM_FADE_EN is defined);
  - the compare;
  - the output flop.
- The top level owns the prescaler, step counter, wrap and period_start logic, and the enable/invert shadows.

Test Plan:
- Reset value and duty 0:
  - Stimulus: reset asserted mid-run; then duty=0x00, prescale=0, enable=1.
  - Response: pwm_out=0 during reset; after release, pwm_out[0] stays 0 for 3 full periods.
- Duty 0x40, prescale 0, enable 1:
  - Response: pwm_out[0] high for 64 consecutive clocks, low for 191.
  - period_start pulses every 255 clocks; the first pulse comes one clock after enable.
- Duty 0xFF, with invert=1 then invert=0:
  - Response: output constant 0 (invert=1); after the next wrap, constant 1 (invert=0).
- Prescale 3, duty 0x02:
  - Response: high 8 clocks per 1020-clock period.
- Mid-period duty write:
  - Stimulus: at step 10, duty_in changes 0x80 -> 0x10.
  - Response: the current period remains high for 128 steps; the next period is high for 16 steps.
- Enable dropped at step 100:
  - Response: pwm_out=0 and active=0 on the next clock.
  - Re-enable restarts with period_start one clock later.
  - With PWM_FADE_EN, a duty 0x00 -> 0x03 request yields high-widths of 1, 2, 3 steps over successive periods.
